// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives the command memory address and
// registers the fetched word with its PC for decode. Handles stall, redirect
// with wrong-path squash and sticky misalignment flag.
// Optional halt-on-syscall support is compiled in with INSTR_FETCH_HALT_DETECT_EN.
module instr_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 'hC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] command_in,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  resume,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [ADDR_WIDTH-1:0] inst_pc_plus4,
  output logic                  inst_valid,
  output logic                  halted,
  output logic                  align_err,
  output logic [31:0]           fetch_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                state_q, state_nx;
  logic [ADDR_WIDTH-1:0] pc_q, pc_nx;
  logic [DATA_WIDTH-1:0] inst_nx;
  logic [ADDR_WIDTH-1:0] ipc_nx, ip4_nx;
  logic                  valid_q, valid_nx;
  logic                  halted_q, halted_nx;
  logic                  align_q, align_nx;
  logic [31:0]           cnt_q, cnt_nx;

  logic [ADDR_WIDTH-1:0] target_pc;
  logic                  target_misaligned;
  logic                  halt_hit;
  logic                  resume_en;

  assign target_pc         = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign target_misaligned = |redirect_pc[1:0];

`ifdef INSTR_FETCH_HALT_DETECT_EN
  assign halt_hit  = (command_in == HALT_WORD);
  assign resume_en = resume;
`else
  // Without halt detection the FSM never leaves RUN, so resume has no effect.
  logic unused_resume;
  assign unused_resume = resume;
  assign halt_hit      = 1'b0;
  assign resume_en     = 1'b0;
`endif

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_nx = state_q;
    pc_nx    = pc_q;
    inst_nx  = inst_out;
    ipc_nx   = inst_pc;
    ip4_nx   = inst_pc_plus4;
    valid_nx = valid_q;
    align_nx = align_q;
    cnt_nx   = cnt_q;
    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_nx    = target_pc;
          valid_nx = 1'b0;
          align_nx = align_q | target_misaligned;
        end else if (!stall) begin
          inst_nx  = command_in;
          ipc_nx   = pc_q;
          ip4_nx   = pc_q + ADDR_WIDTH'(4);
          valid_nx = 1'b1;
          pc_nx    = pc_q + ADDR_WIDTH'(4);
          cnt_nx   = cnt_q + 32'd1;
          if (halt_hit) state_nx = HALT;
        end
      end
      HALT: begin
        // The halting instruction was already issued; stall is ignored here.
        valid_nx = 1'b0;
        if (redirect) begin
          pc_nx    = target_pc;
          align_nx = align_q | target_misaligned;
        end
        if (resume_en) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
    // halted rises one edge after entry, i.e. once the halting word has been
    // presented with inst_valid=1 for a cycle, and drops on the resume edge.
    halted_nx = (state_q == HALT) && (state_nx == HALT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inst_out      <= '0;
      inst_pc       <= '0;
      inst_pc_plus4 <= '0;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
      align_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_nx;
      pc_q          <= pc_nx;
      inst_out      <= inst_nx;
      inst_pc       <= ipc_nx;
      inst_pc_plus4 <= ip4_nx;
      valid_q       <= valid_nx;
      halted_q      <= halted_nx;
      align_q       <= align_nx;
      cnt_q         <= cnt_nx;
    end
  end

  assign read_addr   = pc_q;
  assign inst_valid  = valid_q;
  assign halted      = halted_q;
  assign align_err   = align_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: the driver steps a behavioural model and
// queues the expected post-edge outputs; a monitor pops and compares each edge.
module tb_instr_fetch;

`ifdef INSTR_FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [31:0] HW = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, stall = 1'b0, redirect = 1'b0, resume = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] read_addr, command_in, inst_out, inst_pc, inst_pc_plus4, fetch_count;
  logic        inst_valid, halted, align_err;

  logic        z0 = 1'b0;
  logic [31:0] z32 = '0;
  logic [31:0] ra_w, cmd_w, io_w, ipc_w, ip4_w, fc_w;
  logic        iv_w, hl_w, ae_w;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  assign command_in = mem[read_addr[9:2]];
  assign cmd_w      = mem[ra_w[9:2]];

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .command_in(command_in),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4),
    .inst_valid(inst_valid), .halted(halted), .align_err(align_err),
    .fetch_count(fetch_count)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .read_addr(ra_w), .command_in(cmd_w),
    .stall(z0), .redirect(z0), .redirect_pc(z32), .resume(z0),
    .inst_out(io_w), .inst_pc(ipc_w), .inst_pc_plus4(ip4_w),
    .inst_valid(iv_w), .halted(hl_w), .align_err(ae_w), .fetch_count(fc_w)
  );

  typedef struct {
    logic [31:0] ra, io, ipc, ip4, fc;
    logic        iv, hl, ae;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: architectural view of the fetch unit.
  logic [31:0] m_pc;
  bit          m_in_halt;
  exp_t        m_e;

  task automatic model_step(input bit r, input bit st, input bit rd,
                            input logic [31:0] rpc, input bit rs);
    logic [31:0] word;
    if (!r) begin
      m_pc = 32'h0; m_in_halt = 1'b0;
      m_e.io = 0; m_e.ipc = 0; m_e.ip4 = 0; m_e.fc = 0;
      m_e.iv = 0; m_e.hl = 0; m_e.ae = 0;
    end else if (m_in_halt) begin
      if (rd) begin
        m_pc = rpc & ~32'h3;
        if (rpc % 4 != 0) m_e.ae = 1'b1;
      end
      m_e.iv = 1'b0;
      if (rs) begin m_in_halt = 1'b0; m_e.hl = 1'b0; end
      else m_e.hl = 1'b1;
    end else begin
      if (rd) begin
        m_pc = rpc & ~32'h3;
        if (rpc % 4 != 0) m_e.ae = 1'b1;
        m_e.iv = 1'b0;
      end else if (!st) begin
        word   = mem[(m_pc / 4) % 256];
        m_e.io = word; m_e.ipc = m_pc; m_e.ip4 = m_pc + 4;
        m_e.iv = 1'b1; m_e.fc = m_e.fc + 1;
        m_pc   = m_pc + 4;
        if (HALT_EN && word == HW) m_in_halt = 1'b1;
      end
      m_e.hl = 1'b0;
    end
    m_e.ra = m_pc;
    exp_q.push_back(m_e);
  endtask

  // One clock: drive inputs at the falling edge, predict, let the rising edge happen.
  task automatic cyc(input bit r, input bit st, input bit rd,
                     input logic [31:0] rpc, input bit rs, input bit mut = 1'b0);
    @(negedge clk);
    if (mut) mem[$urandom_range(0, 255)] = ($urandom % 3 == 0) ? HW : $urandom;
    rst_n = r; stall = st; redirect = rd; redirect_pc = rpc; resume = rs;
    model_step(r, st, rd, rpc, rs);
    @(posedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  // Monitor: one expected record per rising edge, compared just after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("read_addr",     read_addr,           e.ra);
        chk("inst_out",      inst_out,            e.io);
        chk("inst_pc",       inst_pc,             e.ipc);
        chk("inst_pc_plus4", inst_pc_plus4,       e.ip4);
        chk("inst_valid",    32'(inst_valid),     32'(e.iv));
        chk("halted",        32'(halted),         32'(e.hl));
        chk("align_err",     32'(align_err),      32'(e.ae));
        chk("fetch_count",   fetch_count,         e.fc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;

    // Reset, then free run; wrap instance walks FFFF_FFF8 -> FFFF_FFFC -> 0.
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    #2 chk("wrap_ra0", ra_w, 32'hFFFF_FFF8);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    cyc(1, 0, 0, 0, 0);
    #2 chk("wrap_ra1", ra_w, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0);
    #2 chk("wrap_ra2", ra_w, 32'h0000_0000);
    chk("wrap_ipc", ipc_w, 32'hFFFF_FFFC);
    run(2);
    #2 chk("run4_count", fetch_count, 32'd4);
    chk("run4_inst", inst_out, 32'h1000_0003);

    // Stall three cycles at pc=8, then stall+redirect (redirect wins).
    cyc(0, 0, 0, 0, 0);
    run(2);
    repeat (3) cyc(1, 1, 0, 0, 0);
    #2 chk("stall_pc", read_addr, 32'h8);
    chk("stall_count", fetch_count, 32'd2);
    cyc(1, 1, 1, 32'h20, 0);
    #2 chk("stall_redir_pc", read_addr, 32'h20);
    run(2);

    // Redirect at pc=10 to 40, then misaligned redirect to 43.
    cyc(0, 0, 0, 0, 0);
    run(4);
    cyc(1, 0, 1, 32'h40, 0);
    #2 chk("bubble_valid", 32'(inst_valid), 32'h0);
    run(1);
    #2 chk("target_pc", inst_pc, 32'h40);
    cyc(1, 0, 1, 32'h43, 0);
    #2 chk("misalign_pc", read_addr, 32'h40);
    chk("align_err", 32'(align_err), 32'h1);
    run(3);

    // Halt word at pc=C; stall ignored while halted; resume; redirect+resume.
    #1 mem[3] = HW;
    cyc(0, 0, 0, 0, 0);
    run(4);
    #2 chk("halt_issue_pc", inst_pc, 32'hC);
    run(1);
    #2 chk("halt_flag", 32'(halted), 32'(HALT_EN));
    chk("halt_pc", read_addr, HALT_EN ? 32'h10 : 32'h14);
    cyc(1, 1, 0, 0, 0);
    run(1);
    cyc(1, 0, 0, 0, 1);
    run(2);
    cyc(1, 0, 1, 32'hC, 0);
    run(3);
    cyc(1, 0, 1, 32'h43, 1);
    run(2);
    // Reset while halted, and reset mid-stall.
    cyc(1, 0, 1, 32'hC, 0);
    run(3);
    cyc(0, 0, 0, 0, 0);
    #2 chk("rst_halt_pc", read_addr, 32'h0);
    run(2);
    repeat (2) cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    #2 chk("rst_stall_cnt", fetch_count, 32'h0);

    // Randomized traffic with sporadic memory rewrites including halt words.
    for (int i = 0; i < 3000; i++) begin
      rpc = 32'($urandom_range(0, 255)) << 2;
      if ($urandom % 4 == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom % 10 == 0) rpc = rpc | 32'hFFFF_FC00;
      cyc(($urandom % 60) != 0, ($urandom % 5) == 0, ($urandom % 7) == 0,
          rpc, ($urandom % 3) == 0, ($urandom % 8) == 0);
    end

    @(posedge clk);
    #2 chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
